// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter with configurable width, parity and stop bits
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                                  clk,
    input  logic                                  rst_i,
    input  logic [DATA_BITS-1:0]                  din_i,
    input  logic                                  wr_en_i,
    output logic                                  full_o,
    output logic                                  empty_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]       fifo_count_o,
    output logic                                  tx_o,
    output logic                                  busy_o,
    output logic                                  tx_done_tick_o
);
    localparam int CPB = CLK_FREQ / BAUD;
    localparam int BW  = $clog2(CPB);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CPB - 1);
    localparam logic [BW-1:0] DONE_AT   = BW'(CPB - 2);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
    localparam logic          ODD       = PARITY == 1;
    localparam logic          HAS_PAR   = PARITY != 0;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY_BIT, STOP} state_t;

    state_t                state;
    logic [DATA_BITS-1:0]  mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [DATA_BITS-1:0]  shreg;
    logic                  par_bit;
    logic [BW-1:0]         baud_cnt;
    logic [3:0]            bit_cnt;
    logic                  push, pop, bit_end, frame_end;
    logic [CW-1:0]         count_nxt;

    // Handshake between FIFO and FSM: a pop happens whenever the line is free for a new frame
    always_comb begin
        bit_end   = baud_cnt == BAUD_LAST;
        frame_end = state == STOP && bit_end && bit_cnt == STOP_LAST;
        push      = wr_en_i && !full_o;
        pop       = !empty_o && (state == IDLE || frame_end);
        count_nxt = fifo_count_o + CW'(push) - CW'(pop);
    end

    // Storage array; writes are harmless during reset since the pointers are cleared
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= din_i;

    // Pointers and registered occupancy flags
    always_ff @(posedge clk) begin
        if (rst_i) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count_o <= '0;
            full_o       <= 1'b0;
            empty_o      <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            fifo_count_o <= count_nxt;
            full_o       <= count_nxt == FULL_CNT;
            empty_o      <= count_nxt == '0;
        end
    end

    // Frame sequencer; every bit period lasts CPB cycles and all line outputs are registered
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state          <= IDLE;
            tx_o           <= 1'b1;
            busy_o         <= 1'b0;
            tx_done_tick_o <= 1'b0;
            baud_cnt       <= '0;
            bit_cnt        <= '0;
            shreg          <= '0;
            par_bit        <= 1'b0;
        end else begin
            tx_done_tick_o <= state == STOP && bit_cnt == STOP_LAST && baud_cnt == DONE_AT;
            baud_cnt       <= bit_end ? '0 : baud_cnt + BW'(1);
            if (pop) begin
                state    <= START;
                tx_o     <= 1'b0;
                busy_o   <= 1'b1;
                baud_cnt <= '0;
                bit_cnt  <= '0;
                shreg    <= mem[rd_ptr];
                par_bit  <= ^mem[rd_ptr] ^ ODD;
            end else begin
                case (state)
                    START: if (bit_end) begin
                        state <= DATA;
                        tx_o  <= shreg[0];
                    end
                    DATA: if (bit_end) begin
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            state   <= HAS_PAR ? PARITY_BIT : STOP;
                            tx_o    <= HAS_PAR ? par_bit : 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                            shreg   <= shreg >> 1;
                            tx_o    <= shreg[1];
                        end
                    end
                    PARITY_BIT: if (bit_end) begin
                        state <= STOP;
                        tx_o  <= 1'b1;
                    end
                    STOP: if (bit_end) begin
                        if (bit_cnt == STOP_LAST) begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for the FIFO-buffered UART transmitter at 10 clocks per bit
module tb_uart_tx_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] din_m = '0, din_e = '0, din_d = '0;
    logic [6:0] din_7 = '0;
    logic wr_m = 0, wr_e = 0, wr_d = 0, wr_7 = 0;
    logic full_m, empty_m, tx_m, busy_m, done_m;
    logic full_e, empty_e, tx_e, busy_e, done_e;
    logic full_d, empty_d, tx_d, busy_d, done_d;
    logic full_7, empty_7, tx_7, busy_7, done_7;
    logic [4:0] cnt_m, cnt_e, cnt_d, cnt_7;

    uart_tx_fifo #(.CLK_FREQ(100_000_000), .BAUD(10_000_000)) dut_m (
        .clk(clk), .rst_i(rst), .din_i(din_m), .wr_en_i(wr_m), .full_o(full_m), .empty_o(empty_m),
        .fifo_count_o(cnt_m), .tx_o(tx_m), .busy_o(busy_m), .tx_done_tick_o(done_m));
    uart_tx_fifo #(.CLK_FREQ(100_000_000), .BAUD(10_000_000), .PARITY(2)) dut_e (
        .clk(clk), .rst_i(rst), .din_i(din_e), .wr_en_i(wr_e), .full_o(full_e), .empty_o(empty_e),
        .fifo_count_o(cnt_e), .tx_o(tx_e), .busy_o(busy_e), .tx_done_tick_o(done_e));
    uart_tx_fifo #(.CLK_FREQ(100_000_000), .BAUD(10_000_000), .PARITY(1)) dut_d (
        .clk(clk), .rst_i(rst), .din_i(din_d), .wr_en_i(wr_d), .full_o(full_d), .empty_o(empty_d),
        .fifo_count_o(cnt_d), .tx_o(tx_d), .busy_o(busy_d), .tx_done_tick_o(done_d));
    uart_tx_fifo #(.CLK_FREQ(100_000_000), .BAUD(10_000_000), .DATA_BITS(7), .STOP_BITS(2)) dut_7 (
        .clk(clk), .rst_i(rst), .din_i(din_7), .wr_en_i(wr_7), .full_o(full_7), .empty_o(empty_7),
        .fifo_count_o(cnt_7), .tx_o(tx_7), .busy_o(busy_7), .tx_done_tick_o(done_7));

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int sel = 0;
    logic tx_s, done_s, busy_s;

    always @(posedge clk) if (done_m) done_cnt <= done_cnt + 1;

    always_comb begin
        tx_s   = sel == 1 ? tx_e   : sel == 2 ? tx_d   : sel == 3 ? tx_7   : tx_m;
        done_s = sel == 1 ? done_e : sel == 2 ? done_d : sel == 3 ? done_7 : done_m;
        busy_s = sel == 1 ? busy_e : sel == 2 ? busy_d : sel == 3 ? busy_7 : busy_m;
    end

    // Called on the negedge right after the push edge; bits[c] is the c-th line bit of the frame
    task automatic check_frame(input int s, input logic [12:0] bits, input int nb, input string name);
        sel = s;
        for (int c = 0; c < nb * 10; c++) begin
            @(negedge clk);
            checks++;
            if (tx_s !== bits[c/10]) begin
                errors++;
                $display("FAIL %s tx cycle %0d got %b want %b", name, c, tx_s, bits[c/10]);
            end
            checks++;
            if (done_s !== 1'(c == nb * 10 - 1)) begin
                errors++;
                $display("FAIL %s done cycle %0d got %b want %b", name, c, done_s, c == nb * 10 - 1);
            end
            checks++;
            if (busy_s !== 1'b1) begin
                errors++;
                $display("FAIL %s busy cycle %0d got %b want 1", name, c, busy_s);
            end
        end
    endtask

    task automatic check_idle(input string name);
        @(negedge clk);
        checks++;
        if (busy_s !== 1'b0 || tx_s !== 1'b1 || done_s !== 1'b0) begin
            errors++;
            $display("FAIL %s idle got busy=%b tx=%b done=%b want 0 1 0", name, busy_s, tx_s, done_s);
        end
    endtask

    task automatic check_cnt(input string name, input logic [4:0] want);
        checks++;
        if (cnt_m !== want) begin
            errors++;
            $display("FAIL %s count got %0d want %0d", name, cnt_m, want);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks += 6;
        if (tx_m !== 1'b1)    begin errors++; $display("FAIL reset tx got %b want 1", tx_m); end
        if (busy_m !== 1'b0)  begin errors++; $display("FAIL reset busy got %b want 0", busy_m); end
        if (done_m !== 1'b0)  begin errors++; $display("FAIL reset done got %b want 0", done_m); end
        if (full_m !== 1'b0)  begin errors++; $display("FAIL reset full got %b want 0", full_m); end
        if (empty_m !== 1'b1) begin errors++; $display("FAIL reset empty got %b want 1", empty_m); end
        if (cnt_m !== 5'd0)   begin errors++; $display("FAIL reset count got %0d want 0", cnt_m); end
    endtask

    task automatic test_single;
        int d0;
        d0 = done_cnt;
        din_m = 8'hA5;
        wr_m = 1'b1;
        @(negedge clk);
        wr_m = 1'b0;
        checks += 2;
        if (empty_m !== 1'b0) begin errors++; $display("FAIL single empty got %b want 0", empty_m); end
        if (tx_m !== 1'b1)    begin errors++; $display("FAIL single pre-start tx got %b want 1", tx_m); end
        check_cnt("single", 5'd1);
        check_frame(0, {1'b1, 8'hA5, 1'b0}, 10, "single");
        check_idle("single");
        checks++;
        if (done_cnt - d0 != 1) begin errors++; $display("FAIL single ticks got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_back_to_back;
        int d0;
        d0 = done_cnt;
        din_m = 8'hA5;
        wr_m = 1'b1;
        @(negedge clk);
        check_cnt("b2b first", 5'd1);
        din_m = 8'h3C;
        fork
            begin
                check_frame(0, {1'b1, 8'hA5, 1'b0}, 10, "b2b a5");
                check_frame(0, {1'b1, 8'h3C, 1'b0}, 10, "b2b 3c");
                check_frame(0, {1'b1, 8'hFF, 1'b0}, 10, "b2b ff");
                check_idle("b2b");
            end
            begin
                @(negedge clk);
                check_cnt("b2b push+pop", 5'd1);
                din_m = 8'hFF;
                @(negedge clk);
                wr_m = 1'b0;
                check_cnt("b2b third", 5'd2);
            end
        join
        repeat (20) @(negedge clk);
        checks++;
        if (done_cnt - d0 != 3) begin errors++; $display("FAIL b2b ticks got %0d want 3", done_cnt - d0); end
    endtask

    task automatic test_parity_width;
        din_e = 8'hA5;
        wr_e = 1'b1;
        @(negedge clk);
        wr_e = 1'b0;
        check_frame(1, {1'b1, 1'b0, 8'hA5, 1'b0}, 11, "even");
        check_idle("even");
        din_d = 8'hA5;
        wr_d = 1'b1;
        @(negedge clk);
        wr_d = 1'b0;
        check_frame(2, {1'b1, 1'b1, 8'hA5, 1'b0}, 11, "odd");
        check_idle("odd");
        din_7 = 7'h55;
        wr_7 = 1'b1;
        @(negedge clk);
        wr_7 = 1'b0;
        check_frame(3, {2'b11, 7'h55, 1'b0}, 10, "7n2");
        check_idle("7n2");
        sel = 0;
    endtask

    task automatic test_full;
        int d0;
        d0 = done_cnt;
        din_m = 8'h40;
        wr_m = 1'b1;
        @(negedge clk);
        din_m = 8'h41;
        fork
            begin
                for (int i = 0; i <= 16; i++) check_frame(0, {1'b1, 8'(8'h40 + i), 1'b0}, 10, "full");
                check_idle("full");
            end
            begin
                for (int i = 2; i <= 16; i++) begin
                    @(negedge clk);
                    din_m = 8'(8'h40 + i);
                end
                @(negedge clk);
                checks++;
                if (full_m !== 1'b1) begin errors++; $display("FAIL full flag got %b want 1", full_m); end
                check_cnt("full", 5'd16);
                din_m = 8'h77;
                @(negedge clk);
                wr_m = 1'b0;
                checks++;
                if (full_m !== 1'b1) begin errors++; $display("FAIL full after drop got %b want 1", full_m); end
                check_cnt("full drop", 5'd16);
            end
        join
        repeat (20) @(negedge clk);
        checks++;
        if (done_cnt - d0 != 17) begin errors++; $display("FAIL full ticks got %0d want 17", done_cnt - d0); end
    endtask

    task automatic test_reset_mid;
        int d0, lows;
        d0 = done_cnt;
        lows = 0;
        din_m = 8'h11;
        wr_m = 1'b1;
        @(negedge clk);
        din_m = 8'h22;
        @(negedge clk);
        din_m = 8'h33;
        @(negedge clk);
        din_m = 8'h44;
        @(negedge clk);
        wr_m = 1'b0;
        check_cnt("rstmid queued", 5'd3);
        repeat (40) @(negedge clk);
        checks++;
        if (busy_m !== 1'b1) begin errors++; $display("FAIL rstmid busy before got %b want 1", busy_m); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks += 3;
        if (tx_m !== 1'b1)    begin errors++; $display("FAIL rstmid tx got %b want 1", tx_m); end
        if (empty_m !== 1'b1) begin errors++; $display("FAIL rstmid empty got %b want 1", empty_m); end
        if (busy_m !== 1'b0)  begin errors++; $display("FAIL rstmid busy got %b want 0", busy_m); end
        check_cnt("rstmid", 5'd0);
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (tx_m !== 1'b1 || busy_m !== 1'b0) lows++;
        end
        checks += 2;
        if (lows != 0) begin errors++; $display("FAIL rstmid activity cycles got %0d want 0", lows); end
        if (done_cnt != d0) begin errors++; $display("FAIL rstmid ticks got %0d want 0", done_cnt - d0); end
    endtask

    task automatic test_wrap;
        din_m = 8'h80;
        wr_m = 1'b1;
        @(negedge clk);
        din_m = 8'h81;
        fork
            begin
                for (int k = 0; k < 32; k++) check_frame(0, {1'b1, 8'(8'h80 + k), 1'b0}, 10, "wrap");
                check_idle("wrap");
            end
            begin
                @(negedge clk);
                din_m = 8'h82;
                @(negedge clk);
                wr_m = 1'b0;
                check_cnt("wrap fill", 5'd2);
                for (int k = 3; k < 32; k++) begin
                    repeat (k == 3 ? 98 : 99) @(negedge clk);
                    din_m = 8'(8'h80 + k);
                    wr_m = 1'b1;
                    @(negedge clk);
                    wr_m = 1'b0;
                    check_cnt("wrap push+pop", 5'd2);
                end
            end
        join
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_parity_width();
        test_full();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter that replaces the fixed 8N1 `uart_tx`. It adds a write-side FIFO and configurable data width, parity and stop bits, and derives the baud tick internally from the clock frequency. Producers push words without waiting for `tx_done_tick_o`. Frames leave back-to-back on `tx_o`, which feeds the board UART pin and carries host-bound AES results.

## Interface
- `CLK_FREQ`, 100_000_000: clock frequency in Hz.
- `BAUD`, 115200: line rate. `CLKS_PER_BIT` = `CLK_FREQ/BAUD`, truncated. Legal result is ≥ 2.
- `DATA_BITS`, 8: payload width, 5..9.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 16: power of two, ≥ 2.

Ports:
- `clk`  in  1  system clock. Single domain.
- `rst_i`  in  1  reset. Synchronous, active-high.
- `din_i`  in  DATA_BITS  word to transmit.
- `wr_en_i`  in  1  push `din_i`. Accepted only when `full_o`=0.
- `full_o`  out  1  FIFO holds FIFO_DEPTH words.
- `empty_o`  out  1  FIFO holds 0 words.
- `fifo_count_o`  out  $clog2(FIFO_DEPTH+1)  words currently stored.
- `tx_o`  out  1  serial line. Idles high.
- `busy_o`  out  1  a frame is on the line.
- `tx_done_tick_o`  out  1  one-cycle pulse in the last cycle of each frame.

## Operation
- The FIFO is synchronous, circular, with read/write pointers of width $clog2(FIFO_DEPTH). Pointers wrap from FIFO_DEPTH-1 to 0.
  - A write when `full_o`=1 is dropped silently. Contents and count are unchanged.
  - Push and pop in the same cycle leave the count unchanged.
  - When full, a same-cycle pop does not allow the push. `full_o` is evaluated before the edge.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE → START when `empty_o`=0. On that transition the head word is popped into the shift register, and the bit counter and baud counter are cleared.
- Each state holds `tx_o` for exactly CLKS_PER_BIT cycles. The baud counter runs 0..CLKS_PER_BIT-1 and then wraps.
  - START drives 0.
  - DATA drives bits LSB first, DATA_BITS of them.
  - PARITY is entered only if PARITY≠0. It drives XOR of the data bits for even parity, and its inverse for odd parity.
  - STOP drives 1 for STOP_BITS bit periods.
- Exit from the last STOP cycle:
  - If the FIFO is non-empty: pop and go directly to START, with no idle gap.
  - Otherwise go to IDLE.
- Frame length is (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles.
- `busy_o`=1 in every non-IDLE state.
- All outputs are registered.

## Timing
- Reset values: `tx_o`=1, `busy_o`=0, `tx_done_tick_o`=0, `full_o`=0, `empty_o`=1, `fifo_count_o`=0. FSM in IDLE. Pointers at 0.
- Reset mid-frame: on the next edge `tx_o` returns to 1 and the FIFO is flushed. The aborted frame produces no done tick.
- Push latency: the write is captured at edge N, so `empty_o` falls after edge N.
  - FSM pops at edge N+1, so `tx_o`=0 from edge N+1.
- `tx_done_tick_o` is high for the final clock of the last stop bit. That is the cycle starting at edge N+1+frame_len-1.
  - In back-to-back mode the next start bit begins on the following edge.
- `full_o`, `empty_o` and `fifo_count_o` update on the same edge as the push or pop that changes them.

## Test plan
Bench settings for all scenarios: CLK_FREQ=100e6, BAUD=10e6 (CLKS_PER_BIT=10), 8N1 unless stated.
1. Reset, then push 0xA5 → `tx_o` sequence is 0,1,0,1,0,0,1,0,1,1, each held 10 cycles. Start bit begins one cycle after the write edge. `tx_done_tick_o` is one cycle, 100 cycles after the start-bit edge minus 1. `busy_o` drops the cycle after the tick.
2. Push 0xA5, 0x3C, 0xFF on consecutive cycles → three 100-cycle frames with no idle gap. `fifo_count_o` reads 1, then 2. Exactly three done ticks.
3. PARITY=2 (even) with 0xA5 → parity bit 0. PARITY=1 (odd) → parity bit 1. Frame is 110 cycles. DATA_BITS=7 with 0x55 and STOP_BITS=2 → 7 data bits, two stop periods.
4. While one frame transmits, push FIFO_DEPTH more words → `full_o`=1. An extra push with 0x77 is dropped. Exactly 1+FIFO_DEPTH frames are emitted, and 0x77 never appears.
5. Assert `rst_i` for one cycle in the middle of the DATA state with 3 words queued → next edge `tx_o`=1, `empty_o`=1, `fifo_count_o`=0. No done tick and no further frames.
6. Push and pop in the same cycle with count=2 → count stays 2, and word order is preserved across pointer wrap (write 2×FIFO_DEPTH sequential values).
